// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one word-wide data memory between two requesters
//            (A = CPU load/store path, B = loader/debug path). Each access
//            is a grant -> issue -> respond transaction: IDLE -> ISSUE -> RESP.
// Ports    : clk, rst_n (async, active low)
//            a_req/a_we/a_addr/a_wdata -> a_ack/a_rdata   requester A
//            b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata   requester B
//            mem_read/mem_write/mem_addr/mem_wdata, mem_rdata  memory side
//            busy (state != IDLE), owner (last granted port, 0=A 1=B)
//            misalign_err (only with MISALIGN_CHECK_EN)
// Options  : `define MISALIGN_CHECK_EN to reject non-word-aligned addresses
//            without touching memory; they complete with misalign_err=1.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
`ifdef MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                owner_q,     owner_d;
  logic                rr_ptr_q,    rr_ptr_d;
  logic                we_l_q,      we_l_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                a_ack_q,     a_ack_d;
  logic                b_ack_q,     b_ack_d;
  // Set only for a RESP that follows a real memory read; steers mem_rdata
  // to the owner. Writes and rejected accesses return zero.
  logic                rd_route_q,  rd_route_d;
`ifdef MISALIGN_CHECK_EN
  logic                merr_q,      merr_d;
`endif

  // Tie-break choice when both ports request in the same IDLE cycle.
  logic tie_pick_b;

  if (FIXED_PRIO != 0) begin : g_fixed_prio
    assign tie_pick_b = 1'b0;
  end else begin : g_round_robin
    assign tie_pick_b = rr_ptr_q;
  end

  // Winner selection and its request fields, muxed once for the IDLE branch.
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pick_b    = b_req & (~a_req | tie_pick_b);
  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  // The issued address/data registers double as the latched request, so a
  // requester changing its bus after grant cannot disturb the access.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    we_l_d      = we_l_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    rd_route_d  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    merr_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d  = pick_b;
          rr_ptr_d = ~pick_b;
          we_l_d   = sel_we;
`ifdef MISALIGN_CHECK_EN
          if (sel_addr[1:0] != 2'b00) begin
            // Memory is never touched; complete straight from RESP.
            state_d = RESP;
            a_ack_d = ~pick_b;
            b_ack_d = pick_b;
            merr_d  = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
`else
          state_d     = ISSUE;
          mem_read_d  = ~sel_we;
          mem_write_d = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
`endif
        end
      end
      ISSUE: begin
        state_d    = RESP;
        a_ack_d    = ~owner_q;
        b_ack_d    = owner_q;
        rd_route_d = ~we_l_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      we_l_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      rd_route_q  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      merr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      we_l_q      <= we_l_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      rd_route_q  <= rd_route_d;
`ifdef MISALIGN_CHECK_EN
      merr_q      <= merr_d;
`endif
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  // Memory registers its read data on the issue edge, so it is valid
  // throughout RESP and can be routed straight through.
  assign a_rdata   = (a_ack_q && rd_route_q) ? mem_rdata : '0;
  assign b_rdata   = (b_ack_q && rd_route_q) ? mem_rdata : '0;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
`ifdef MISALIGN_CHECK_EN
  assign misalign_err = merr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter. Instance dut is round-robin,
//            instance fdut uses fixed priority. Expected memory operations and
//            acknowledgements are queued by the stimulus; monitors pop and
//            compare whenever the DUT presents one.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // round-robin instance
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, mem_read, mem_write, busy, owner;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  // fixed-priority instance
  logic        f_a_req, f_a_we, f_b_req, f_b_we;
  logic [31:0] f_a_addr, f_a_wdata, f_b_addr, f_b_wdata;
  logic        f_a_ack, f_b_ack, f_mem_read, f_mem_write, f_busy, f_owner;
  logic [31:0] f_a_rdata, f_b_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_err, f_misalign_err;
`endif

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
`ifdef MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .owner(owner)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .FIXED_PRIO(1)) fdut (
    .clk(clk), .rst_n(rst_n),
    .a_req(f_a_req), .a_we(f_a_we), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_ack(f_b_ack), .b_rdata(f_b_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .busy(f_busy),
`ifdef MISALIGN_CHECK_EN
    .misalign_err(f_misalign_err),
`endif
    .owner(f_owner)
  );

  // Memory model for dut: 64 words indexed by addr[7:2], registered read.
  logic [31:0] mem [0:63];
  logic        mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'hCAFEF00D;
    end else begin
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end
  end
  // Memory model for fdut: read data is a fixed pattern of the address.
  always @(posedge clk) begin
    if (f_mem_read) f_mem_rdata <= f_mem_addr ^ 32'h5A5A0000;
  end

  typedef struct packed { logic port; logic [31:0] rdata; logic merr; } ack_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } op_t;
  ack_t ack_q[$];
  ack_t f_ack_q[$];
  op_t  op_q[$];
  ack_t e_ack, f_e_ack;
  op_t  e_op;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor for dut: memory operations and acknowledgements.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read || mem_write) begin
        total++;
        if (op_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_mem_op: read=%b write=%b addr=%h", mem_read, mem_write, mem_addr);
        end else begin
          e_op = op_q.pop_front();
          check("mem_write", {31'b0, mem_write}, {31'b0, e_op.we});
          check("mem_read",  {31'b0, mem_read},  {31'b0, ~e_op.we});
          check("mem_addr",  mem_addr, e_op.addr);
          if (e_op.we) check("mem_wdata", mem_wdata, e_op.wdata);
        end
      end
      if (a_ack || b_ack) begin
        total++;
        if (ack_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: a_ack=%b b_ack=%b", a_ack, b_ack);
        end else begin
          e_ack = ack_q.pop_front();
          check("ack_a", {31'b0, a_ack}, {31'b0, ~e_ack.port});
          check("ack_b", {31'b0, b_ack}, {31'b0, e_ack.port});
          check("owner", {31'b0, owner}, {31'b0, e_ack.port});
          check("rdata", e_ack.port ? b_rdata : a_rdata, e_ack.rdata);
          check("other_rdata", e_ack.port ? a_rdata : b_rdata, 32'h0);
`ifdef MISALIGN_CHECK_EN
          check("misalign_err", {31'b0, misalign_err}, {31'b0, e_ack.merr});
`endif
        end
      end
    end
  end

  // Monitor for fdut: grant order via acknowledgements.
  always @(negedge clk) begin
    if (rst_n && (f_a_ack || f_b_ack)) begin
      total++;
      if (f_ack_q.size() == 0) begin
        bad++;
        $display("FAIL f_unexpected_ack: a_ack=%b b_ack=%b", f_a_ack, f_b_ack);
      end else begin
        f_e_ack = f_ack_q.pop_front();
        check("f_ack_b", {31'b0, f_b_ack}, {31'b0, f_e_ack.port});
        check("f_ack_a", {31'b0, f_a_ack}, {31'b0, ~f_e_ack.port});
        check("f_owner", {31'b0, f_owner}, {31'b0, f_e_ack.port});
        check("f_rdata", f_e_ack.port ? f_b_rdata : f_a_rdata, f_e_ack.rdata);
      end
    end
  end

  // One request on dut from an idle arbiter. Latency is counted in negedges
  // from the raise (inside the IDLE cycle): ack arrives at the third, or the
  // second for a rejected misaligned access.
  task automatic single(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int   n;
    int   lat;
    logic skip;
    ack_t ea;
    op_t  eo;
    skip = 1'b0;
`ifdef MISALIGN_CHECK_EN
    skip = (addr[1:0] != 2'b00);
`endif
    lat = skip ? 2 : 3;
    ea.port  = port;
    ea.rdata = skip ? 32'h0 : exp_rdata;
    ea.merr  = skip;
    ack_q.push_back(ea);
    if (!skip) begin
      eo.we = we; eo.addr = addr; eo.wdata = wdata;
      op_q.push_back(eo);
    end
    @(posedge clk); #1;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2)
        check("issue_enables", {30'b0, mem_read, mem_write},
              skip ? 32'h0 : {30'b0, ~we, we});
    end while (!(port ? b_ack : a_ack) && n < 20);
    check("ack_latency", n, lat);
    a_req = 0; b_req = 0;
    // scramble the bus after completion; must not matter
    a_addr = 32'hFFFF_FFF0; b_addr = 32'hFFFF_FFF0;
  endtask

  initial begin
    int n, na, nacks;
    ack_t ea;
    op_t  eo;
    rst_n = 0; mem_load = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    f_a_req = 0; f_a_we = 0; f_a_addr = 0; f_a_wdata = 0;
    f_b_req = 0; f_b_we = 0; f_b_addr = 0; f_b_wdata = 0;
    repeat (3) @(posedge clk);
    #1 mem_load = 0;
    check("rst_outputs", {26'b0, a_ack, b_ack, mem_read, mem_write, busy, owner}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'h0);

    // basic single transactions
    single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    single(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0);
    single(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678);
    // unaligned: passed through by default, rejected with the check enabled
    single(1'b0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF);

    // reset during ISSUE of a B write to 0x30
    @(posedge clk); #1;
    b_req = 1; b_we = 1; b_addr = 32'h30; b_wdata = 32'h11112222;
    @(posedge clk); #1;
    check("mid_issue_write", {30'b0, mem_write, busy}, 32'h3);
    check("mid_issue_owner", {31'b0, owner}, 32'h1);
    #1 rst_n = 0;
    #1;
    check("mid_rst_async", {29'b0, mem_write, busy, b_ack}, 32'h0);
    b_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_idle", {29'b0, busy, b_ack, owner}, 32'h0);
    end

    // both held on dut: A,B,A,B; A reads 0x30 (write must not have landed)
    for (int k = 0; k < 4; k++) begin
      ea.port = k[0]; ea.merr = 0;
      ea.rdata = k[0] ? 32'hDEADBEEF : 32'hCAFEF00D;
      ack_q.push_back(ea);
      eo.we = 0; eo.wdata = 0; eo.addr = k[0] ? 32'h10 : 32'h30;
      op_q.push_back(eo);
    end
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 32'h30;
    b_req = 1; b_we = 0; b_addr = 32'h10;
    n = 0; nacks = 0;
    while (nacks < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (a_ack || b_ack) nacks++;
    end
    a_req = 0; b_req = 0;
    check("rr_cycles", n, 12);

    // fixed priority on fdut: A wins three times, then B after A drops
    for (int k = 0; k < 4; k++) begin
      ea.port = (k == 3); ea.merr = 0;
      ea.rdata = (k == 3) ? 32'h5A5A0044 : 32'h5A5A0040;
      f_ack_q.push_back(ea);
    end
    @(posedge clk); #1;
    f_a_req = 1; f_a_we = 0; f_a_addr = 32'h40;
    f_b_req = 1; f_b_we = 0; f_b_addr = 32'h44;
    n = 0; na = 0;
    while (!f_b_ack && n < 60) begin
      @(negedge clk);
      n++;
      if (f_a_ack) begin
        na++;
        if (na == 3) f_a_req = 0;
      end
    end
    f_b_req = 0;
    check("fp_cycles", n, 12);

    repeat (5) @(posedge clk);
    check("ack_q_empty", ack_q.size(), 0);
    check("op_q_empty", op_q.size(), 0);
    check("f_ack_q_empty", f_ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
